// File: rtl/keypad_entry_ctrl_pkg.sv
// Shared types and helpers for the keypad entry controller.
//   state_t    : controller state (IDLE, ENTRY, COMMIT)
//   key_code_t : 4-bit key code; digits 0-9 use their own value,
//                letters A-D are 4'hA-4'hD, '*' is 4'hE, '#' is 4'hF.
//   key_info_t : decoded view of one row/column sample.
// NO_KEY shares its encoding with KEY_0. The decoder flags
// (onehot_ok, is_digit, ...) say whether value is meaningful, so the
// overlap is harmless.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  typedef logic [3:0] key_code_t;

  localparam key_code_t KEY_0    = 4'h0;
  localparam key_code_t KEY_1    = 4'h1;
  localparam key_code_t KEY_2    = 4'h2;
  localparam key_code_t KEY_3    = 4'h3;
  localparam key_code_t KEY_4    = 4'h4;
  localparam key_code_t KEY_5    = 4'h5;
  localparam key_code_t KEY_6    = 4'h6;
  localparam key_code_t KEY_7    = 4'h7;
  localparam key_code_t KEY_8    = 4'h8;
  localparam key_code_t KEY_9    = 4'h9;
  localparam key_code_t KEY_A    = 4'hA;
  localparam key_code_t KEY_B    = 4'hB;
  localparam key_code_t KEY_C    = 4'hC;
  localparam key_code_t KEY_D    = 4'hD;
  localparam key_code_t KEY_STAR = 4'hE;
  localparam key_code_t KEY_HASH = 4'hF;
  localparam key_code_t NO_KEY   = 4'h0;

  typedef struct packed {
    logic      is_digit;
    logic      is_cmd;
    logic      is_star;
    logic      is_hash;
    key_code_t value;
    logic      onehot_ok;
  } key_info_t;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Bit position of a one-hot nibble; only meaningful when is_onehot4(v).
  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Physical layout: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D.
  function automatic key_code_t map_key(input logic [1:0] r, input logic [1:0] c);
    key_code_t k;
    case ({r, c})
      4'h0: k = KEY_1;    4'h1: k = KEY_2;    4'h2: k = KEY_3;    4'h3: k = KEY_A;
      4'h4: k = KEY_4;    4'h5: k = KEY_5;    4'h6: k = KEY_6;    4'h7: k = KEY_B;
      4'h8: k = KEY_7;    4'h9: k = KEY_8;    4'hA: k = KEY_9;    4'hB: k = KEY_C;
      4'hC: k = KEY_STAR; 4'hD: k = KEY_0;    4'hE: k = KEY_HASH; default: k = KEY_D;
    endcase
    return k;
  endfunction

  // Letter key to command code: A=0, B=1, C=2, D=3.
  function automatic logic [1:0] cmd_index(input key_code_t k);
    logic [1:0] code;
    case (k)
      KEY_B:   code = 2'd1;
      KEY_C:   code = 2'd2;
      KEY_D:   code = 2'd3;
      default: code = 2'd0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// Committed-entry handshake between the keypad controller and the host.
//   entry_valid : committed entry available (driven by master)
//   entry_ready : consumer accepts the entry (driven by slave)
//   entry_bcd   : committed digits, right-aligned BCD, newest in [3:0]
//   entry_len   : number of digits in the committed entry
// Handshake: a transfer happens on every clock edge where entry_valid and
// entry_ready are both high. Once raised, entry_valid, entry_bcd and
// entry_len hold steady until that transfer; entry_valid drops the next
// cycle. entry_ready is ignored while entry_valid is low.
interface keypad_entry_ctrl_if #(
  parameter int DIGITS = 4
) ();
  logic                  entry_valid;
  logic                  entry_ready;
  logic [4*DIGITS-1:0]   entry_bcd;
  logic [3:0]            entry_len;

  modport master (
    output entry_valid,
    output entry_bcd,
    output entry_len,
    input  entry_ready
  );

  modport slave (
    input  entry_valid,
    input  entry_bcd,
    input  entry_len,
    output entry_ready
  );
endinterface

// File: rtl/keypad_entry_ctrl_key_decoder.sv
// Combinational key decoder.
//   row_in : latched scanner row, expected one-hot
//   col_in : active scanner column, expected one-hot
//   info   : {is_digit, is_cmd, is_star, is_hash, value, onehot_ok}
// When either input is not exactly one-hot every flag is 0 and value is
// NO_KEY, so the caller only needs onehot_ok to reject the event.
module keypad_key_decoder
  import keypad_pkg::*;
(
  input  logic [3:0] row_in,
  input  logic [3:0] col_in,
  output key_info_t  info
);

  key_code_t code;

  always_comb begin
    info           = '0;
    info.value     = NO_KEY;
    code           = map_key(onehot_idx(row_in), onehot_idx(col_in));
    info.onehot_ok = is_onehot4(row_in) && is_onehot4(col_in);
    if (info.onehot_ok) begin
      info.value    = code;
      info.is_digit = (code <= KEY_9);
      info.is_cmd   = (code >= KEY_A) && (code <= KEY_D);
      info.is_star  = (code == KEY_STAR);
      info.is_hash  = (code == KEY_HASH);
    end
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: turns scanner key-held level plus one-hot
// row/column into key events, collects decimal digits into a BCD buffer,
// and hands committed entries to the host.
//   clk, reset   : single clock, synchronous active-high reset
//   key_pressed  : scanner "key held" level
//   row_in/col_in: scanner row/column, one-hot
//   entry        : committed-entry handshake (master side)
//   cmd_valid    : one-cycle pulse on a letter key, cmd_code = A..D as 0..3
//   err          : one-cycle pulse on a rejected key event
//   timeout      : one-cycle pulse when a partial entry is discarded
//   state        : current controller state, for observation
// All outputs are registered and update the cycle after the key edge is
// seen.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int          DIGITS        = 4,
  parameter logic [23:0] TIMEOUT_TICKS = 24'd12_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 key_pressed,
  input  logic [3:0]           row_in,
  input  logic [3:0]           col_in,
  keypad_entry_ctrl_if.master  entry,
  output logic                 cmd_valid,
  output logic [1:0]           cmd_code,
  output logic                 err,
  output logic                 timeout,
  output state_t               state
);

  localparam int BW = 4 * DIGITS;

  state_t      state_q;
  logic [BW-1:0] buf_q;
  logic [3:0]  len_q;
  logic [23:0] cnt_q;
  logic        key_q;
  logic        entry_valid_q;
  logic [BW-1:0] entry_bcd_q;
  logic [3:0]  entry_len_q;
  logic        cmd_valid_q;
  logic [1:0]  cmd_code_q;
  logic        err_q;
  logic        timeout_q;

  key_info_t   key;
  logic        key_event;

  keypad_key_decoder u_dec (
    .row_in (row_in),
    .col_in (col_in),
    .info   (key)
  );

  // key_q clears on reset, so a key already held at reset release
  // produces exactly one event.
  assign key_event = key_pressed && !key_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      buf_q         <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      key_q         <= 1'b0;
      entry_valid_q <= 1'b0;
      entry_bcd_q   <= '0;
      entry_len_q   <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_code_q    <= '0;
      err_q         <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      key_q       <= key_pressed;
      cmd_valid_q <= 1'b0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;

      // The handshake completes independently of any key event in the
      // same cycle; such an event is still judged against COMMIT below
      // and never touches state there, so the two do not collide.
      if (state_q == COMMIT && entry_valid_q && entry.entry_ready) begin
        entry_valid_q <= 1'b0;
        state_q       <= IDLE;
      end

      if (key_event) begin
        // A key event always restarts inactivity timing, which also lets
        // it win over a timeout falling in the same cycle.
        cnt_q <= '0;
        if (!key.onehot_ok) begin
          err_q <= 1'b1;
        end else if (key.is_cmd) begin
          cmd_valid_q <= 1'b1;
          cmd_code_q  <= cmd_index(key.value);
        end else begin
          unique case (state_q)
            IDLE: begin
              if (key.is_digit) begin
                buf_q   <= BW'(key.value);
                len_q   <= 4'd1;
                state_q <= ENTRY;
              end else if (key.is_hash) begin
                err_q <= 1'b1;
              end else begin
                buf_q <= '0;
                len_q <= '0;
              end
            end
            ENTRY: begin
              if (key.is_digit) begin
                if (len_q == 4'(DIGITS)) begin
                  err_q <= 1'b1;
                end else begin
                  buf_q <= (buf_q << 4) | BW'(key.value);
                  len_q <= len_q + 4'd1;
                end
              end else if (key.is_hash) begin
                entry_bcd_q   <= buf_q;
                entry_len_q   <= len_q;
                entry_valid_q <= 1'b1;
                buf_q         <= '0;
                len_q         <= '0;
                state_q       <= COMMIT;
              end else begin
                buf_q   <= '0;
                len_q   <= '0;
                state_q <= IDLE;
              end
            end
            default: begin
              err_q <= 1'b1;
            end
          endcase
        end
      end else if (state_q == ENTRY) begin
        if (cnt_q == TIMEOUT_TICKS - 24'd1) begin
          buf_q     <= '0;
          len_q     <= '0;
          cnt_q     <= '0;
          state_q   <= IDLE;
          timeout_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 24'd1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign entry.entry_valid = entry_valid_q;
  assign entry.entry_bcd   = entry_bcd_q;
  assign entry.entry_len   = entry_len_q;
  assign cmd_valid         = cmd_valid_q;
  assign cmd_code          = cmd_code_q;
  assign err               = err_q;
  assign timeout           = timeout_q;
  assign state             = state_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed scenarios followed by randomized
// key traffic, all checked every cycle against a queue-based entry model.
module tb_keypad_entry_ctrl;
  import keypad_pkg::*;

  localparam int          DIGITS = 4;
  localparam int          TO     = 16;
  localparam logic [23:0] TO_P   = 24'd16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        key_pressed;
  logic [3:0]  row_in;
  logic [3:0]  col_in;
  logic        cmd_valid;
  logic [1:0]  cmd_code;
  logic        err;
  logic        timeout;
  state_t      state;

  keypad_entry_ctrl_if #(.DIGITS(DIGITS)) ent ();

  keypad_entry_ctrl #(.DIGITS(DIGITS), .TIMEOUT_TICKS(TO_P)) dut (
    .clk         (clk),
    .reset       (reset),
    .key_pressed (key_pressed),
    .row_in      (row_in),
    .col_in      (col_in),
    .entry       (ent.master),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .err         (err),
    .timeout     (timeout),
    .state       (state)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_err    = 0;

  string km = "123A456B789C*0#D";

  bit          m_prev;
  int          m_dig[$];
  bit          m_commit;
  logic [15:0] m_bcd;
  logic [3:0]  m_len;
  logic [1:0]  m_code;
  int          m_idle;
  bit          exp_err, exp_cmd, exp_to;

  bit          rand_ready = 1'b0;
  logic [15:0] last_bcd;
  logic [3:0]  last_len;
  logic [1:0]  last_code;
  int          err_cnt = 0;
  int          to_cnt  = 0;
  int          cmd_cnt = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int bit_pos(input logic [3:0] v);
    int p = 0;
    for (int i = 0; i < 4; i++) if (v[i]) p = i;
    return p;
  endfunction

  // Applies the keypad rules to what is on the inputs at this clock edge.
  task automatic model_step();
    bit  ev, was_commit;
    byte ch;
    exp_err = 1'b0; exp_cmd = 1'b0; exp_to = 1'b0;
    if (reset) begin
      m_prev = 1'b0; m_dig.delete(); m_commit = 1'b0;
      m_bcd = '0; m_len = '0; m_code = '0; m_idle = 0;
      return;
    end
    ev         = key_pressed && !m_prev;
    m_prev     = key_pressed;
    was_commit = m_commit;
    if (ev) begin
      m_idle = 0;
      if ($countones(row_in) != 1 || $countones(col_in) != 1) begin
        exp_err = 1'b1;
      end else begin
        ch = km[bit_pos(row_in) * 4 + bit_pos(col_in)];
        if (ch >= "A" && ch <= "D") begin
          exp_cmd = 1'b1;
          m_code  = 2'(ch - "A");
        end else if (was_commit) begin
          exp_err = 1'b1;
        end else if (ch == "*") begin
          m_dig.delete();
        end else if (ch == "#") begin
          if (m_dig.size() == 0) exp_err = 1'b1;
          else begin
            m_bcd = '0;
            foreach (m_dig[i]) m_bcd = {m_bcd[11:0], 4'(m_dig[i])};
            m_len    = 4'(m_dig.size());
            m_commit = 1'b1;
            m_dig.delete();
          end
        end else begin
          if (m_dig.size() == DIGITS) exp_err = 1'b1;
          else m_dig.push_back(int'(ch - "0"));
        end
      end
    end else if (!was_commit && m_dig.size() > 0) begin
      m_idle++;
      if (m_idle == TO) begin
        exp_to = 1'b1;
        m_dig.delete();
        m_idle = 0;
      end
    end
    if (was_commit && ent.entry_ready) m_commit = 1'b0;
  endtask

  function automatic state_t exp_state();
    if (m_commit) return COMMIT;
    if (m_dig.size() > 0) return ENTRY;
    return IDLE;
  endfunction

  // One clock: model at the edge, compare at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (ent.entry_valid) begin last_bcd = ent.entry_bcd; last_len = ent.entry_len; end
    if (cmd_valid) begin last_code = cmd_code; cmd_cnt++; end
    if (err) err_cnt++;
    if (timeout) to_cnt++;
    check("err",         32'(err),             32'(exp_err));
    check("cmd_valid",   32'(cmd_valid),       32'(exp_cmd));
    check("timeout",     32'(timeout),         32'(exp_to));
    check("entry_valid", 32'(ent.entry_valid), 32'(m_commit));
    check("entry_bcd",   32'(ent.entry_bcd),   32'(m_bcd));
    check("entry_len",   32'(ent.entry_len),   32'(m_len));
    check("cmd_code",    32'(cmd_code),        32'(m_code));
    check("state",       32'(state),           32'(exp_state()));
    if (rand_ready) ent.entry_ready = ($urandom_range(0, 2) == 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic press_rc(input logic [3:0] r, input logic [3:0] c, input int hold, input int gap);
    row_in = r; col_in = c; key_pressed = 1'b1;
    repeat (hold) tick();
    key_pressed = 1'b0; row_in = '0; col_in = '0;
    repeat (gap) tick();
  endtask

  task automatic press(input byte ch, input int hold = 1, input int gap = 2);
    int idx = 0;
    for (int i = 0; i < 16; i++) if (km[i] == ch) idx = i;
    press_rc(4'(1 << (idx / 4)), 4'(1 << (idx % 4)), hold, gap);
  endtask

  // ---------------- stimulus ----------------
  int e0, t0;

  initial begin
    reset = 1'b1; key_pressed = 1'b0; row_in = '0; col_in = '0;
    ent.entry_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // 1 2 3 # with ready high: single-cycle valid
    ent.entry_ready = 1'b1;
    press("1"); press("2"); press("3"); press("#", 1, 3);
    check("tp1_bcd", 32'(last_bcd), 32'h0123);
    check("tp1_len", 32'(last_len), 32'd3);

    // overflow on the fifth digit
    e0 = err_cnt;
    press("9"); press("8"); press("7"); press("6"); press("5");
    check("tp2_overflow_err", 32'(err_cnt - e0), 32'd1);
    press("#", 1, 3);
    check("tp2_bcd", 32'(last_bcd), 32'h9876);
    check("tp2_len", 32'(last_len), 32'd4);

    // clear then single digit; '#' from IDLE
    press("4"); press("*"); press("7"); press("#", 1, 3);
    check("tp3_bcd", 32'(last_bcd), 32'h0007);
    check("tp3_len", 32'(last_len), 32'd1);
    e0 = err_cnt;
    press("#");
    check("tp3_idle_hash_err", 32'(err_cnt - e0), 32'd1);

    // inactivity timeout, then '#' is rejected
    t0 = to_cnt;
    press("5", 1, 20);
    check("tp4_timeout", 32'(to_cnt - t0), 32'd1);
    e0 = err_cnt;
    press("#");
    check("tp4_hash_err", 32'(err_cnt - e0), 32'd1);

    // commit stalled by consumer
    ent.entry_ready = 1'b0;
    press("1"); press("#", 1, 3);
    e0 = err_cnt;
    press("7", 1, 3);
    press("B", 1, 3);
    check("tp5_digit_err", 32'(err_cnt - e0), 32'd1);
    check("tp5_cmd_code",  32'(last_code),    32'd1);
    ent.entry_ready = 1'b1;
    tick(); tick();
    ent.entry_ready = 1'b0;

    // handshake and letter in the same cycle
    press("2"); press("#", 1, 1);
    ent.entry_ready = 1'b1;
    press("D", 1, 2);
    ent.entry_ready = 1'b0;

    // invalid row pattern
    press("6");
    e0 = err_cnt;
    press_rc(4'b0011, 4'b0001, 1, 2);
    check("tp6_invalid_err", 32'(err_cnt - e0), 32'd1);
    press("#", 1, 2);

    // reset mid-COMMIT, with a key held across reset release
    press("3"); press("#", 1, 2);
    reset = 1'b1;
    tick();
    check("rst_valid", 32'(ent.entry_valid), 32'd0);
    check("rst_state", 32'(state),           32'(IDLE));
    row_in = 4'b0001; col_in = 4'b0100; key_pressed = 1'b1;
    tick();
    reset = 1'b0;
    tick(); tick();
    key_pressed = 1'b0; row_in = '0; col_in = '0;
    tick();
    ent.entry_ready = 1'b1;
    press("#", 1, 2);

    // randomized traffic
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      int hold = $urandom_range(1, 3);
      int gap  = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20) : $urandom_range(1, 4);
      if ($urandom_range(0, 9) == 0)
        press_rc(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), hold, gap);
      else
        press(km[$urandom_range(0, 15)], hold, gap);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_entry_ctrl.md
# keypad_entry_ctrl

Sequencing controller above the 4x4 keypad scanner. It turns the scanner's debounced key-held level and one-hot row/column lines into discrete key events. Decimal digits go into a BCD entry buffer; the block handles clear, commit and inactivity timeout. A completed entry is handed to the host logic over a valid/ready handshake, and letter keys are forwarded as one-cycle command pulses.

## Interface
- DIGITS, 4, maximum digits per entry (1..8); sets entry_bcd width to 4*DIGITS.
- TIMEOUT_TICKS, 24'd12_000_000, clk cycles of inactivity after which a partial entry is discarded.
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- key_pressed  in  1  scanner "key held" level.
- row_in  in  4  scanner latched row, one-hot; bit r means row r.
- col_in  in  4  scanner active column, one-hot; bit c means column c.
- entry_valid  out  1  committed entry available.
- entry_ready  in  1  consumer accepts entry.
- entry_bcd  out  4*DIGITS  committed digits, right-aligned BCD, most recent digit in [3:0].
- entry_len  out  4  number of digits in the committed entry.
- cmd_valid  out  1  one-cycle pulse on a letter key.
- cmd_code  out  2  letter key: 0=A, 1=B, 2=C, 3=D.
- err  out  1  one-cycle pulse on a rejected key event.
- timeout  out  1  one-cycle pulse when a partial entry is discarded.

## Operation
- Key map, row/col: r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = * 0 # D.
- Key event: rising edge of key_pressed, detected by comparing against a registered copy. row_in/col_in are sampled in the same cycle.
- Invalid event: row_in or col_in not exactly one-hot. The event is dropped with an err pulse and the buffer is unchanged.
- States:
  - IDLE: buffer empty.
  - ENTRY: 1..DIGITS digits held.
  - COMMIT: entry_valid high.
- Digit event:
  - In IDLE: buffer becomes {0..,d}, len becomes 1, state goes to ENTRY.
  - In ENTRY with len < DIGITS: buffer shifts left 4 bits, d is inserted, len increments.
  - In ENTRY with len == DIGITS: digit ignored, err pulse.
- '*': clears buffer and len to 0 and goes to IDLE from IDLE or ENTRY. No err.
- '#':
  - In ENTRY: copies buffer and len to entry_bcd and entry_len, asserts entry_valid, clears the working buffer, goes to COMMIT.
  - In IDLE: err pulse, no commit.
- Letter key: cmd_valid pulse with cmd_code in any state, including COMMIT. State and buffer are unaffected.
- COMMIT:
  - Digit, '*' and '#' events are dropped with an err pulse.
  - entry_valid, entry_bcd and entry_len stay stable until entry_valid && entry_ready; then the block goes to IDLE.
- Timeout:
  - The inactivity counter resets on every key event and counts only in ENTRY.
  - At TIMEOUT_TICKS-1 the buffer is cleared, state goes to IDLE and timeout pulses.
  - The counter is held at 0 in IDLE and COMMIT.
- Reset: state IDLE; buffer, entry_bcd, entry_len, cmd_code and counter all 0; entry_valid, cmd_valid, err and timeout all 0. The edge-detect register clears to 0, so a key already held when reset releases counts as one event.

## Timing
- Event latency:
  - Edge is seen in cycle N, when key_pressed=1 and the registered copy is 0.
  - Outputs and state updated in cycle N+1: entry_valid, cmd_valid, err and buffer.
- cmd_valid, err and timeout are high for exactly one cycle per cause. At most one of cmd_valid/err is high per event.
- Handshake: transfer occurs on the cycle with entry_valid && entry_ready. entry_valid is low the following cycle. entry_ready while entry_valid is low has no effect.
- Simultaneous handshake and key event in the same cycle: the event is evaluated against COMMIT (dropped with err, or cmd_valid for a letter). The handshake still completes.
- A timeout and a key event in the same cycle: the key event wins and the counter restarts.
- Holding a key produces one event only. A new event requires key_pressed to go low first.

## Structure
- Shared package keypad_pkg:
  - state enum (IDLE, ENTRY, COMMIT);
  - 4-bit key code type with constants for digits 0-9 and KEY_STAR, KEY_HASH, KEY_A..KEY_D;
  - NO_KEY constant 4'b0000.
- Sub-module keypad_key_decoder: combinational. Maps one-hot row_in/col_in to {is_digit, is_cmd, is_star, is_hash, value[3:0], onehot_ok}.
- The top level holds the edge detect, FSM, shift buffer, length counter and timeout counter.

## Test plan
- Keys 1, 2, 3, '#' with entry_ready=1 → entry_valid one cycle; entry_bcd=16'h0123, entry_len=3; then IDLE.
- Keys 9, 8, 7, 6, 5 with DIGITS=4 → fifth key gives an err pulse. Then '#' → entry_bcd=16'h9876, entry_len=4.
- Keys 4, '*', 7, '#' → entry_bcd=16'h0007, entry_len=1. '#' from IDLE → err pulse, no entry_valid.
- TIMEOUT_TICKS=16:
  - key 5 then 16 idle cycles → timeout pulse in the cycle after count 15; state IDLE.
  - '#' afterwards → err.
- Commit with entry_ready=0 for 10 cycles:
  - entry_bcd and entry_valid stable; a digit event gives err; key B gives cmd_valid with cmd_code=1.
  - entry_ready=1 → transfer, then IDLE.
- Invalid input and reset:
  - row_in=4'b0011 on an edge → err, buffer unchanged.
  - reset asserted mid-COMMIT → all outputs 0 the next cycle, state IDLE.
